// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// the core load/store path (c_) and an auxiliary master (a_), with read return routing.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [15:0]       conflict_cnt
);

  // state  | meaning
  // OWN_C  | core held the most recent grant; aux wins the next conflict
  // OWN_A  | aux held the most recent grant; core wins the next conflict
  typedef enum logic {OWN_C = 1'b0, OWN_A = 1'b1} owner_e;

  owner_e            owner_q, owner_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              gnt_c, gnt_a, rd_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_A;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grants are gated by rst_n so every output is quiet while reset is held.
  always_comb begin
    gnt_c       = 1'b0;
    gnt_a       = 1'b0;
    owner_d     = owner_q;
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (rst_n) begin
      if (c_req && (!a_req || owner_q == OWN_A)) begin
        gnt_c = 1'b1;
      end else if (a_req) begin
        gnt_a = 1'b1;
      end
    end
    if (gnt_c) begin
      owner_d     = OWN_C;
      mem_address = c_addr;
      mem_data    = c_wdata;
      mem_wren    = c_we;
    end else if (gnt_a) begin
      owner_d     = OWN_A;
      mem_address = a_addr;
      mem_data    = a_wdata;
      mem_wren    = a_we;
    end
  end

  assign rd_push = (gnt_c && !c_we) || (gnt_a && !a_we);

  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = rd_push;
    own_d[0] = gnt_a;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (c_req && a_req && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end

  // The last pipeline stage lines up with mem_q for the read it tracks.
  assign c_gnt        = gnt_c;
  assign a_gnt        = gnt_a;
  assign c_rvalid     = vld_q[RD_LAT-1] && !own_q[RD_LAT-1];
  assign a_rvalid     = vld_q[RD_LAT-1] && own_q[RD_LAT-1];
  assign c_rdata      = c_rvalid ? mem_q : '0;
  assign a_rdata      = a_rvalid ? mem_q : '0;
  assign conflict_cnt = cnt_q;

endmodule
